// File: rtl/serial_rx_gen.sv
// serial_rx_gen: parametrised oversampling UART receiver.
// Two-flop synchroniser, free-running tick divider, 2-of-3 mid-bit majority
// vote, and a valid/ready holding register carrying per-word parity, framing
// and break status plus a sticky overrun flag.

module serial_rx_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK_100_I,
  input  logic                 RST_I,
  input  logic                 SERIAL_I,
  output logic [DATA_BITS-1:0] DATA_O,
  output logic                 VALID_O,
  input  logic                 READY_I,
  output logic                 PARITY_ERR_O,
  output logic                 FRAME_ERR_O,
  output logic                 BREAK_O,
  output logic                 OVERRUN_O,
  output logic                 BUSY_O
);

  localparam int DIV   = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int M     = OVERSAMPLE / 2;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);

  // Reject configurations the datapath cannot represent.
  if (DIV < 1) begin : g_bad_div
    $error("serial_rx_gen: clock too slow for BAUD*OVERSAMPLE (DIV < 1)");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("serial_rx_gen: OVERSAMPLE must be even and in 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("serial_rx_gen: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("serial_rx_gen: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("serial_rx_gen: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [SC_W-1:0]      sc;
  logic [BC_W-1:0]      bit_cnt;
  logic                 stop_cnt;
  logic                 s0, s1, vote;
  logic                 vote_tick, bit_end, last_stop, done;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, par_low, frame_acc, stops_low;
  logic                 brk_now;

  // Two-flop synchroniser on the asynchronous line; idles high out of reset.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK_100_I) begin
    if (RST_I) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= SERIAL_I;
      rx_s    <= rx_meta;
    end
  end

  // Free-running divider producing a one-cycle tick every DIV clocks.
  always_ff @(posedge CLK_100_I) begin
    if (RST_I)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // 2-of-3 vote over the samples at sc = M-1, M and the live sample at M+1.
  assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign vote_tick = tick && (state != S_IDLE) && (sc == SC_W'(M + 1));
  assign bit_end   = tick && (state != S_IDLE) && (sc == SC_W'(OVERSAMPLE - 1));
  assign last_stop = (STOP_BITS == 1) || stop_cnt;

  // State register.
  always_ff @(posedge CLK_100_I) begin
    if (RST_I) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and the completion strobe.
  // NOTE: defaults come first so no path through the case leaves a latch.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (tick && !rx_s) state_next = S_START;
      S_START: begin
        if (vote_tick && vote) state_next = S_IDLE;
        else if (bit_end)      state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_cnt == BC_W'(DATA_BITS - 1))
          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP: begin
        if (vote_tick && last_stop) begin
          state_next = S_IDLE;
          done       = 1'b1;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Bit timing, sampling, shift register and per-frame status accumulation.
  always_ff @(posedge CLK_100_I) begin
    if (RST_I) begin
      sc        <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      par_err   <= 1'b0;
      par_low   <= 1'b1;
      frame_acc <= 1'b0;
      stops_low <= 1'b1;
    end else if (state == S_IDLE) begin
      sc        <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_err   <= 1'b0;
      par_low   <= 1'b1;
      frame_acc <= 1'b0;
      stops_low <= 1'b1;
    end else if (tick) begin
      sc <= (sc == SC_W'(OVERSAMPLE - 1)) ? '0 : sc + 1'b1;
      if (sc == SC_W'(M - 1)) s0 <= rx_s;
      if (sc == SC_W'(M))     s1 <= rx_s;
      if (vote_tick) begin
        case (state)
          S_DATA:   shreg <= {vote, shreg[DATA_BITS-1:1]};
          S_PARITY: begin
            // Odd parity wants an odd count of ones including the parity bit.
            par_err <= ((^shreg) ^ vote) != (PARITY == 1);
            par_low <= ~vote;
          end
          S_STOP: begin
            if (!vote) frame_acc <= 1'b1;
            else       stops_low <= 1'b0;
          end
          default: ;
        endcase
      end
      if (bit_end) begin
        case (state)
          S_DATA:  bit_cnt  <= bit_cnt + 1'b1;
          S_STOP:  stop_cnt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Break: word, parity bit and every stop bit (including the one being voted) low.
  assign brk_now = (shreg == '0) && par_low && stops_low && !vote;

  // Holding register: load on completion when free or being drained, else flag overrun.
  always_ff @(posedge CLK_100_I) begin
    if (RST_I) begin
      DATA_O       <= '0;
      VALID_O      <= 1'b0;
      PARITY_ERR_O <= 1'b0;
      FRAME_ERR_O  <= 1'b0;
      BREAK_O      <= 1'b0;
      OVERRUN_O    <= 1'b0;
    end else if (done) begin
      if (!VALID_O || READY_I) begin
        DATA_O       <= shreg;
        VALID_O      <= 1'b1;
        PARITY_ERR_O <= par_err;
        FRAME_ERR_O  <= frame_acc | ~vote;
        BREAK_O      <= brk_now;
        OVERRUN_O    <= 1'b0;
      end else begin
        OVERRUN_O <= 1'b1;
      end
    end else if (VALID_O && READY_I) begin
      VALID_O   <= 1'b0;
      OVERRUN_O <= 1'b0;
    end
  end

  assign BUSY_O = (state != S_IDLE);

endmodule

// File: tb/tb_serial_rx_gen.sv
// Directed bench for serial_rx_gen: an 8N1 instance (DIV = 2) and a 7E1
// instance (DIV = 1), each with its own line and a capture queue of accepted
// words packed as {break, frame_err, parity_err, data}.

module tb_serial_rx_gen;

  localparam int BT_A = 32;  // clocks per bit, DIV 2 x 16
  localparam int BT_B = 16;  // clocks per bit, DIV 1 x 16

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       line_a, ready_a, valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic       line_b, ready_b, valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;
  logic [6:0] data_b;

  serial_rx_gen #(
    .CLK_HZ(32_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .CLK_100_I(clk), .RST_I(rst), .SERIAL_I(line_a), .DATA_O(data_a),
    .VALID_O(valid_a), .READY_I(ready_a), .PARITY_ERR_O(perr_a),
    .FRAME_ERR_O(ferr_a), .BREAK_O(brk_a), .OVERRUN_O(ovr_a), .BUSY_O(busy_a)
  );

  serial_rx_gen #(
    .CLK_HZ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .CLK_100_I(clk), .RST_I(rst), .SERIAL_I(line_b), .DATA_O(data_b),
    .VALID_O(valid_b), .READY_I(ready_b), .PARITY_ERR_O(perr_b),
    .FRAME_ERR_O(ferr_b), .BREAK_O(brk_b), .OVERRUN_O(ovr_b), .BUSY_O(busy_b)
  );

  int vectors    = 0;
  int miscompares = 0;
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  logic [11:0] w;

  // Capture every accepted word on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid_a && ready_a) q_a.push_back({brk_a, ferr_a, perr_a, 1'b0, data_a});
    if (valid_b && ready_b) q_b.push_back({brk_b, ferr_b, perr_b, 2'b00, data_b});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_a(output logic [11:0] x);
    if (q_a.size() != 0) x = q_a.pop_front();
    else                 x = 'x;
  endtask

  task automatic pop_b(output logic [11:0] x);
    if (q_b.size() != 0) x = q_b.pop_front();
    else                 x = 'x;
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop_lvl);
    line_a = 1'b0;
    tick_n(BT_A);
    for (int i = 0; i < 8; i++) begin
      line_a = d[i];
      tick_n(BT_A);
    end
    line_a = stop_lvl;
    tick_n(BT_A);
    line_a = 1'b1;
  endtask

  task automatic send_b(input logic [6:0] d, input logic p);
    line_b = 1'b0;
    tick_n(BT_B);
    for (int i = 0; i < 7; i++) begin
      line_b = d[i];
      tick_n(BT_B);
    end
    line_b = p;
    tick_n(BT_B);
    line_b = 1'b1;
    tick_n(BT_B);
  endtask

  initial begin
    rst = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    tick_n(4);
    rst = 1'b0;
    check("rst_data_a", data_a, 8'h00);
    check("rst_flags_a", {valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a}, 6'b0);
    check("rst_data_b", data_b, 7'h00);
    check("rst_flags_b", {valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b}, 6'b0);
    tick_n(4);

    // Back-to-back 0x55 then 0xA3 with no idle time between frames.
    send_a(8'h55, 1'b1);
    send_a(8'hA3, 1'b1);
    tick_n(2 * BT_A);
    check("b2b_count", q_a.size(), 2);
    pop_a(w); check("b2b_word0", w, 12'h055);
    pop_a(w); check("b2b_word1", w, 12'h0A3);
    check("b2b_valid_low", valid_a, 1'b0);

    // Even parity, 7 data bits: 0x41 has two ones so the correct parity bit is 0.
    send_b(7'h41, 1'b0);
    send_b(7'h41, 1'b1);
    tick_n(2 * BT_B);
    check("par_count", q_b.size(), 2);
    pop_b(w); check("par_good", w, 12'h041);
    pop_b(w); check("par_bad", w, 12'h241);

    // Stop bit driven low: framing error, data intact.
    send_a(8'h3C, 1'b0);
    tick_n(2 * BT_A);
    check("ferr_count", q_a.size(), 1);
    pop_a(w); check("ferr_word", w, 12'h43C);

    // Line low for 12 bit times: first word is a break; the trailing frame is discarded.
    line_a = 1'b0;
    tick_n(12 * BT_A);
    line_a = 1'b1;
    tick_n(12 * BT_A);
    pop_a(w); check("break_word", w, 12'hC00);
    check("break_idle", busy_a, 1'b0);
    q_a.delete();

    // Quarter-bit glitch: a false start that returns to idle with no output.
    line_a = 1'b0;
    tick_n(6);
    check("glitch_busy_high", busy_a, 1'b1);
    tick_n(2);
    line_a = 1'b1;
    tick_n(BT_A - 8);
    check("glitch_busy_low", busy_a, 1'b0);
    tick_n(BT_A);
    check("glitch_no_word", q_a.size(), 0);
    check("glitch_no_valid", valid_a, 1'b0);

    // Overrun: three frames with the consumer stalled.
    ready_a = 1'b0;
    send_a(8'h11, 1'b1);
    send_a(8'h22, 1'b1);
    send_a(8'h33, 1'b1);
    tick_n(BT_A);
    check("ovr_valid", valid_a, 1'b1);
    check("ovr_data", data_a, 8'h11);
    check("ovr_flag", ovr_a, 1'b1);
    ready_a = 1'b1;
    tick_n(1);
    ready_a = 1'b0;
    check("ovr_accept_valid", valid_a, 1'b0);
    check("ovr_accept_flag", ovr_a, 1'b0);
    check("ovr_data_hold", data_a, 8'h11);
    pop_a(w); check("ovr_accepted_word", w, 12'h011);
    ready_a = 1'b1;

    // Reset mid-data of 0x7E (start, bit0 = 0, bit1 = 1, half of bit2 = 1).
    line_a = 1'b0; tick_n(BT_A);
    line_a = 1'b0; tick_n(BT_A);
    line_a = 1'b1; tick_n(BT_A);
    tick_n(BT_A / 2);
    check("mid_frame_busy", busy_a, 1'b1);
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    check("midrst_data", data_a, 8'h00);
    check("midrst_flags", {valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a}, 6'b0);
    tick_n(12 * BT_A);
    check("midrst_no_word", q_a.size(), 0);
    send_a(8'h81, 1'b1);
    tick_n(2 * BT_A);
    check("after_rst_count", q_a.size(), 1);
    pop_a(w); check("after_rst_word", w, 12'h081);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_rx_gen.md
# serial_rx_gen

Parametrised oversampling UART receiver for the serial input path. It takes the raw asynchronous SERIAL_I line and delivers one DATA_BITS-wide word per frame through a valid/ready holding register. Each word carries its own parity, framing and break status, plus a sticky overrun flag. It is the generalised successor to the fixed 8N1/9600 receiver, and feeds a FIFO or a command parser directly.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- BAUD, 9600: line rate.
- OVERSAMPLE, 16: sample ticks per bit; even, 8..32.
- DATA_BITS, 8: word width; 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- CLK_100_I  in  1  system clock.
- RST_I  in  1  reset; synchronous, active-high.
- SERIAL_I  in  1  asynchronous serial line; idle high.
- DATA_O  out  DATA_BITS  received word, LSB = first bit on the line.
- VALID_O  out  1  DATA_O and the error flags are valid.
- READY_I  in  1  consumer accepts the word when VALID_O && READY_I.
- PARITY_ERR_O  out  1  parity mismatch for the held word; forced 0 when PARITY = 0.
- FRAME_ERR_O  out  1  a stop bit sampled low for the held word.
- BREAK_O  out  1  held word, parity and all stop bits all sampled low.
- OVERRUN_O  out  1  sticky: at least one frame was dropped because the holding register was full.
- BUSY_O  out  1  high in every state except IDLE.

## Operation
- Synchroniser: 2 flops on SERIAL_I, both reset to 1. All logic uses the second flop (rx_s).
- Tick generator:
  - Free-running divider, DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded.
  - Asserts a 1-cycle tick every DIV clocks.
  - Divider width is clog2(DIV + 1). DIV < 1 is a configuration error and elaboration must fail.
- Sub-bit counter `sc`: 0..OVERSAMPLE-1, advances on ticks only, wraps to 0.
- Majority vote:
  - Samples are taken at sc = M-1, M and M+1, where M = OVERSAMPLE/2.
  - Bit value = 2-of-3.
- States:
  - IDLE: on a tick with rx_s = 0, set sc = 0 and go to START.
  - START: at sc = M+1, if the vote is 1 this is a false start: go to IDLE with no output. At sc = OVERSAMPLE-1, go to DATA.
  - DATA: one bit per OVERSAMPLE ticks, shifted in LSB first. After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: vote the bit. err = (^data ^ p) != (PARITY == 1) — odd parity requires an odd count of ones including p.
  - STOP: vote each stop bit; any 0 sets the frame error.
    - First stop bit of two: runs a full OVERSAMPLE ticks.
    - Last stop bit: the state ends at sc = M+1, right after the vote, then goes to IDLE. This lets a back-to-back start edge be caught.
- Completion happens when the last stop bit is voted.
  - If VALID_O = 0, or VALID_O && READY_I in the same cycle: load DATA_O and all flags, and set VALID_O = 1.
  - Otherwise: discard the frame, leave the held word and flags unchanged, and set OVERRUN_O.
- Handshake: VALID_O && READY_I with no simultaneous completion clears VALID_O and OVERRUN_O on the next edge.
- A completion coinciding with an accept reloads the register; OVERRUN_O clears.
- DATA_O holds its value while VALID_O = 0.
- Reset mid-frame abandons the frame. No partial output is produced.

## Timing
- Reset values:
  - DATA_O = 0.
  - VALID_O, PARITY_ERR_O, FRAME_ERR_O, BREAK_O, OVERRUN_O, BUSY_O = 0.
  - State = IDLE, sc = 0, divider = 0.
- Input latency: 2 clocks through the synchroniser, plus up to DIV clocks of tick alignment before IDLE sees the start bit.
- Output latency: VALID_O rises on the clock edge following the tick where sc = M+1 in the last stop bit. At that point the frame length is (1 + DATA_BITS + P + STOP_BITS - 1)*OVERSAMPLE + M + 2 ticks from START entry, where P = 1 if PARITY != 0, else 0.
- Throughput: VALID_O stays high until accepted; READY_I held high gives zero-bubble acceptance.
- BUSY_O rises on the clock after start detection and falls on the clock after the return to IDLE.
- Tolerance: a frame must decode correctly with up to ±3% baud mismatch at OVERSAMPLE = 16.

## Test plan
- Defaults, READY_I = 1: send 0x55, then 0xA3 back-to-back (zero idle time) → two VALID_O pulses, DATA_O = 0x55 then 0xA3, all error flags 0.
- CLK_HZ = 16_000_000, BAUD = 1_000_000 (DIV = 1), PARITY = 2, DATA_BITS = 7: send 0x41 with correct even parity, then 0x41 with the parity bit flipped → PARITY_ERR_O = 0, then 1; DATA_O = 0x41 both times.
- Frame 0x3C with the stop bit driven low → FRAME_ERR_O = 1, DATA_O = 0x3C.
- All-low line for 12 bit times → BREAK_O = 1, FRAME_ERR_O = 1, DATA_O = 0x00.
- 1/4-bit low glitch on an idle line → no VALID_O, BUSY_O returns to 0 within 1 bit time.
- READY_I = 0 while receiving 0x11, 0x22, 0x33 → DATA_O stays 0x11 and OVERRUN_O = 1. Pulse READY_I for 1 cycle → VALID_O = 0 and OVERRUN_O = 0.
- RST_I asserted for 1 cycle mid-data of 0x7E → all outputs return to reset values. The next frame, 0x81, is received correctly.
